// File: rtl/ro_sense_counter.sv
// Ring-oscillator thermal sensor back end: gates the RO, settles it, counts its edges over a CK window.
// Optional RO_SENSE_AVG4_EN averages four back-to-back windows per measurement.
module ro_sense_counter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             RO,
  output logic             EN_RO,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN,
  input  logic             ACK,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVF
);

  localparam int unsigned SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic             ro_edge_c;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next_c;
  logic             cnt_sat_c;
  logic             win_last_c;

`ifdef RO_SENSE_AVG4_EN
  logic [CNT_W+1:0] acc_q;
  logic [CNT_W+1:0] acc_sum_c;
  logic [1:0]       idx_q;
  assign acc_sum_c = acc_q + (CNT_W+2)'(cnt_next_c);
`endif

  // Synchronizer and history flop run in every state so no false edge appears entering COUNT
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= RO;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign ro_edge_c  = s2_q & ~s3_q;
  assign cnt_sat_c  = ro_edge_c && (cnt_q == {CNT_W{1'b1}});
  assign cnt_next_c = (ro_edge_c && !cnt_sat_c) ? cnt_q + CNT_W'(1) : cnt_q;
  assign win_last_c = (win_cnt_q == WIN_W'(1));

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      cnt_q        <= '0;
      EN_RO        <= 1'b0;
      COUNT        <= '0;
      VALID        <= 1'b0;
      BUSY         <= 1'b0;
      OVF          <= 1'b0;
`ifdef RO_SENSE_AVG4_EN
      acc_q        <= '0;
      idx_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && (WIN != '0)) begin
            win_q        <= WIN;
            cnt_q        <= '0;
            COUNT        <= '0;
            OVF          <= 1'b0;
            EN_RO        <= 1'b1;
            BUSY         <= 1'b1;
            settle_cnt_q <= SET_W'(SETTLE_CYC);
`ifdef RO_SENSE_AVG4_EN
            acc_q        <= '0;
            idx_q        <= '0;
`endif
            state_q      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SET_W'(1)) begin
            win_cnt_q <= win_q;
            state_q   <= ST_COUNT;
          end else begin
            settle_cnt_q <= settle_cnt_q - SET_W'(1);
          end
        end
        ST_COUNT: begin
          cnt_q <= cnt_next_c;
          if (cnt_sat_c) OVF <= 1'b1;
          if (win_last_c) begin
`ifdef RO_SENSE_AVG4_EN
            if (idx_q != 2'd3) begin
              // Next window starts on the following cycle with a fresh edge count
              idx_q     <= idx_q + 2'd1;
              acc_q     <= acc_sum_c;
              cnt_q     <= '0;
              win_cnt_q <= win_q;
            end else begin
              COUNT   <= CNT_W'(acc_sum_c >> 2);
              EN_RO   <= 1'b0;
              BUSY    <= 1'b0;
              VALID   <= 1'b1;
              state_q <= ST_DONE;
            end
`else
            COUNT   <= cnt_next_c;
            EN_RO   <= 1'b0;
            BUSY    <= 1'b0;
            VALID   <= 1'b1;
            state_q <= ST_DONE;
`endif
          end else begin
            win_cnt_q <= win_cnt_q - WIN_W'(1);
          end
        end
        ST_DONE: begin
          if (ACK) begin
            VALID   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sense_counter.sv
// Bench for ro_sense_counter: randomized RO periods and windows against an edge-timestamp model,
// with a 4-bit-counter instance sharing the stimulus to cover saturation.
module tb_ro_sense_counter;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned S     = 4;
  localparam int unsigned SAT_W = 4;
`ifdef RO_SENSE_AVG4_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 1;
`endif

  logic             CK = 1'b0;
  logic             RN;
  logic             RO;
  logic             START;
  logic             ACK;
  logic [WIN_W-1:0] WIN;

  logic             en_ro, valid, busy, ovf;
  logic [CNT_W-1:0] count;
  logic             s_en_ro, s_valid, s_busy, s_ovf;
  logic [SAT_W-1:0] s_count;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rises[$];
  int   ro_half = 2;
  logic ro_stuck = 1'b0;

  ro_sense_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(S)) u_dut (
    .CK(CK), .RN(RN), .RO(RO), .EN_RO(en_ro), .START(START), .WIN(WIN), .ACK(ACK),
    .COUNT(count), .VALID(valid), .BUSY(busy), .OVF(ovf)
  );

  ro_sense_counter #(.CNT_W(SAT_W), .WIN_W(WIN_W), .SETTLE_CYC(S)) u_sat (
    .CK(CK), .RN(RN), .RO(RO), .EN_RO(s_en_ro), .START(START), .WIN(WIN), .ACK(ACK),
    .COUNT(s_count), .VALID(s_valid), .BUSY(s_busy), .OVF(s_ovf)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // An RO rise between edges k and k+1 is captured at edge k+1 and counted at edge k+3
  always @(posedge RO) rises.push_back(cyc + 3);

  // RO toggles 2ns before a CK edge so the sample point is never ambiguous
  initial begin
    RO = 1'b0;
    #3;
    forever begin
      if (ro_half == 0) begin
        #10 RO = ro_stuck;
      end else begin
        #(ro_half * 10) RO = ~RO;
      end
    end
  end

  function automatic int edges_in(input int lo, input int hi);
    int n = 0;
    foreach (rises[i]) if (rises[i] >= lo && rises[i] <= hi) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // One measurement: optional START/ACK pestering while busy, optional RO speed-up at offset sw
  task automatic measure(input int w, input bit pester, input int sw, input bit ack_with_start);
    int t, vc, en_n, lim, i, n, sum, ssum, hold;
    bit got, e_ovf, e_sovf;
    START = 1'b1;
    WIN   = WIN_W'(w);
    t     = cyc + 1;
    tick();
    START = 1'b0;
    WIN   = WIN_W'($urandom);
    en_n  = 0;
    got   = 1'b0;
    vc    = 0;
    i     = 0;
    lim   = S + NWIN * w + 10;
    while (!got && i < lim) begin
      if (en_ro) en_n++;
      if (valid) begin
        got = 1'b1;
        vc  = cyc;
      end else begin
        if (sw > 0 && cyc == t + sw) ro_half = 1;
        if (pester && ($urandom_range(3) == 0)) begin
          START = 1'b1;
          WIN   = WIN_W'($urandom_range(200, 1));
          ACK   = 1'b1;
        end
        tick();
        START = 1'b0;
        ACK   = 1'b0;
        i++;
      end
    end
    check("valid_latency", got ? 32'(vc - t) : 32'hffff_ffff, 32'(S + NWIN * w));

    sum = 0; ssum = 0; e_ovf = 1'b0; e_sovf = 1'b0;
    for (int k = 0; k < NWIN; k++) begin
      n = edges_in(t + S + k * w + 1, t + S + (k + 1) * w);
      if (n > 65535) begin sum += 65535; e_ovf = 1'b1; end else sum += n;
      if (n > 15) begin ssum += 15; e_sovf = 1'b1; end else ssum += n;
    end
    check("count", 32'(count), 32'(sum / NWIN));
    check("ovf", 32'(ovf), 32'(e_ovf));
    check("sat_count", 32'(s_count), 32'(ssum / NWIN));
    check("sat_ovf", 32'(s_ovf), 32'(e_sovf));
    check("en_ro_cycles", 32'(en_n), 32'(S + NWIN * w));
    check("busy_at_valid", 32'(busy), 32'd0);

    hold = $urandom_range(2);
    repeat (hold) tick();
    check("valid_hold", 32'(valid), 32'd1);

    ACK = 1'b1;
    if (ack_with_start) begin
      START = 1'b1;
      WIN   = WIN_W'(10);
    end
    tick();
    ACK   = 1'b0;
    START = 1'b0;
    check("valid_after_ack", 32'(valid), 32'd0);
    check("count_after_ack", 32'(count), 32'(sum / NWIN));
    if (ack_with_start) begin
      repeat (3) tick();
      check("start_ack_ignored", 32'({busy, en_ro, s_busy}), 32'd0);
    end else begin
      check("busy_after_ack", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int w;
    RN = 1'b0; START = 1'b0; ACK = 1'b0; WIN = '0;
    #12;
    check("reset_outs", 32'({en_ro, valid, busy, ovf, count}), 32'd0);
    check("reset_sat_outs", 32'({s_en_ro, s_valid, s_busy, s_ovf, s_count}), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    repeat (3) tick();

    // RO period 4 CK, WIN=100: 25 edges, 4-bit instance saturates
    ro_half = 2;
    measure(100, 1'b0, 0, 1'b0);
    check("basic_count_25", 32'(count), 32'd25);
    check("basic_sat_15", 32'({s_ovf, s_count}), 32'h1f);
    measure(8, 1'b0, 0, 1'b0);
    check("after_sat_count_2", 32'({s_ovf, s_count}), 32'h02);

    // START with WIN==0 is ignored
    START = 1'b1; WIN = '0;
    tick();
    START = 1'b0;
    repeat (3) begin
      check("win0_ignored", 32'({busy, en_ro}), 32'd0);
      tick();
    end

    // Pestering with START/ACK while busy, then START+ACK together in DONE
    measure(60, 1'b1, 0, 1'b0);
    measure(30, 1'b0, 0, 1'b1);

    // Stuck RO: no edges, including at the SETTLE->COUNT boundary
    ro_half = 0; ro_stuck = 1'b1;
    repeat (6) tick();
    measure(64, 1'b0, 0, 1'b0);
    check("stuck1_zero", 32'(count), 32'd0);
    ro_stuck = 1'b0;
    repeat (6) tick();
    measure(64, 1'b0, 0, 1'b0);
    check("stuck0_zero", 32'(count), 32'd0);

    // Reset 50 cycles into COUNT aborts the measurement
    ro_half = 2;
    repeat (4) tick();
    START = 1'b1; WIN = WIN_W'(200);
    tick();
    START = 1'b0;
    repeat (S + 49) tick();
    RN = 1'b0;
    #1;
    check("rst_mid_outs", 32'({en_ro, busy, valid, ovf, count}), 32'd0);
    check("rst_mid_sat", 32'({s_en_ro, s_busy, s_valid, s_ovf, s_count}), 32'd0);
    #3 RN = 1'b1;
    tick();
    measure(20, 1'b0, 0, 1'b0);
    check("post_rst_count_5", 32'(count), 32'd5);

    // Period 4 for the first half, period 2 afterwards (four-window averaging scenario)
    ro_half = 2;
    repeat (4) tick();
    measure(40, 1'b0, S + 2 * 40 - 1, 1'b0);

    // Randomized RO speed and window length
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(5) == 0) begin
        ro_half  = 0;
        ro_stuck = 1'($urandom_range(1));
      end else begin
        ro_half = $urandom_range(6, 1);
      end
      w = $urandom_range(250, 1);
      repeat ($urandom_range(4, 1)) tick();
      measure(w, 1'($urandom_range(1)), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_sense_counter.md
Name: ro_sense_counter

Overview:
- Digital back end of an on-die ring-oscillator (RO) thermal sensor. Sits directly downstream of the inverter-chain RO built from the X1M/X2M inverter and AND cells.
- Gates the RO on and lets it settle. Counts RO rising edges over a programmable window of CK cycles, then presents the count to the sensor readout/telemetry logic with a valid/ack handshake.
- The count is proportional to RO frequency, and therefore to local temperature.

Parameters:
- CNT_W, 16, width of the edge counter and of COUNT
- WIN_W, 16, width of the window-length input WIN
- SETTLE_CYC, 4, CK cycles RO runs before counting starts (>=1)

Ports:
- CK  input  1  clock
- RN  input  1  reset. One clock; RN is asynchronous, active-low.
- RO  input  1  raw ring-oscillator output, asynchronous to CK
- EN_RO  output  1  ring-oscillator enable, feeds the RO's AND gate
- START  input  1  single-cycle request to begin a measurement
- WIN  input  WIN_W  window length in CK cycles, sampled with START
- ACK  input  1  consumer has taken COUNT
- COUNT  output  CNT_W  measured edge count
- VALID  output  1  COUNT is valid; held until ACK
- BUSY  output  1  measurement in progress (SETTLE or COUNT state)
- OVF  output  1  counter saturated during the last window

Behaviour:
- Reset (RN low, asynchronous): state=IDLE, EN_RO=0, COUNT=0, VALID=0, BUSY=0, OVF=0, sync flops=0, internal counters=0. Asserting RN mid-measurement aborts immediately; no partial result is produced.
- RO synchronizer: two flops, then a third history flop. Edge detect = s2 & ~s3. RO is only measured correctly if its frequency is below CK/2; above that, edges are lost silently.
- States: IDLE -> SETTLE -> COUNT -> DONE -> IDLE.
- IDLE:
  - START=1 with WIN!=0: latch WIN into win_q, clear the edge counter and OVF, EN_RO=1, BUSY=1 from the next cycle, go to SETTLE.
  - START with WIN==0: ignored; no state change.
- SETTLE:
  - Stays for exactly SETTLE_CYC cycles. Edges are not counted.
  - Sync history flops keep running so the first COUNT cycle does not see a false edge.
- COUNT:
  - Stays for exactly win_q cycles. Each cycle with a detected edge increments the counter.
  - At all-ones the counter holds (saturates) and OVF is set to 1.
- End of COUNT, on the same edge: EN_RO=0, BUSY=0, COUNT=final count, VALID=1, go to DONE.
- Latency: if START is sampled at edge t, VALID rises at edge t+SETTLE_CYC+win_q.
- DONE:
  - COUNT, VALID and OVF hold until ACK=1 is sampled.
  - On ACK: VALID=0, go to IDLE. COUNT and OVF keep their values until the next START.
- ACK outside DONE: ignored.
- START in SETTLE, COUNT or DONE: ignored. This includes START and ACK in the same cycle in DONE; START must be reissued after IDLE is reached.
- Window counter is WIN_W bits and counts down from win_q to 1. WIN = 2^WIN_W-1 is legal.

Optional Feature:
- Macro: RO_SENSE_AVG4_EN.
- Defined:
  - Each START runs 4 back-to-back windows of win_q cycles. EN_RO stays high throughout; SETTLE runs only once, before the first window.
  - Window counts are summed in a CNT_W+2 bit accumulator. COUNT = sum >> 2.
  - OVF = 1 if any window saturated.
  - Latency: t+SETTLE_CYC+4*win_q.
- Undefined: single-window behaviour as described above; no accumulator is synthesized.

Test Plan:
- Basic measurement: RO square wave, period 4 CK; WIN=100; START one cycle. Expect COUNT=25 (±1), OVF=0, VALID at t+104, EN_RO high for exactly 104 cycles. ACK then drops VALID next cycle and BUSY=0.
- Saturation: CNT_W=4, RO period 4 CK, WIN=100. Expect COUNT=15, OVF=1. A following START with WIN=8 gives COUNT=2, OVF=0.
- Ignored requests:
  - START with WIN=0: stays IDLE, EN_RO=0.
  - START pulses during SETTLE/COUNT: no effect on timing or count.
  - START together with ACK in DONE: returns to IDLE with no new measurement.
- Reset mid-operation: drop RN at cycle 50 of the COUNT phase. EN_RO, BUSY, VALID, COUNT and OVF are all 0 asynchronously. After RN release, a new START with WIN=20 and RO period 4 gives COUNT=5.
- RO stuck (constant 1 or 0), WIN=64: COUNT=0, VALID asserted on schedule. No false edge on the SETTLE->COUNT transition.
- With RO_SENSE_AVG4_EN: RO period 4 for windows 1-2 and period 2 for windows 3-4, WIN=40. Expect window counts 10,10,20,20 and COUNT=15, with VALID at t+SETTLE_CYC+160.
